// File: rtl/rgb_pwm_pkg.sv
// rgb_pwm_pkg: register map and default widths for the RGB PWM slave.
// DUTY_ONE is the duty register value that means 100 % on.
package rgb_pwm_pkg;

    localparam int PERIOD_W_DEF = 24;
    localparam int DUTY_W_DEF   = 12;

    localparam logic [1:0] ADDR_PERIOD = 2'd0;
    localparam logic [1:0] ADDR_RED    = 2'd1;
    localparam logic [1:0] ADDR_GREEN  = 2'd2;
    localparam logic [1:0] ADDR_BLUE   = 2'd3;

    localparam int CH_RED   = 2;
    localparam int CH_GREEN = 1;
    localparam int CH_BLUE  = 0;

    localparam int DUTY_ONE = 1 << DUTY_W_DEF;

endpackage

// File: rtl/rgb_pwm_channel.sv
// pwm_channel: one colour of the RGB PWM (threshold, active copy, compare).
// Optional RGB_PWM_ACTIVE_LOW_EN inverts the output for common-anode LEDs.
module pwm_channel
    import rgb_pwm_pkg::*;
#(
    parameter int PERIOD_W = PERIOD_W_DEF,
    parameter int DUTY_W   = DUTY_W_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [PERIOD_W-1:0] period_stage,
    input  logic [DUTY_W:0]     duty_stage,
    input  logic [PERIOD_W-1:0] cnt,
    input  logic                boundary,
    input  logic                run,
    output logic                pwm
);

    localparam int PROD_W = PERIOD_W + DUTY_W + 1;

`ifdef RGB_PWM_ACTIVE_LOW_EN
    localparam logic PWM_IDLE = 1'b1;
`else
    localparam logic PWM_IDLE = 1'b0;
`endif

    logic [PROD_W-1:0]   prod;
    logic [PERIOD_W-1:0] thr;
    logic [PERIOD_W-1:0] thr_act;

    assign prod = PROD_W'(period_stage) * PROD_W'(duty_stage);

    // Register the scaled threshold so the multiplier has a full cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            thr <= '0;
        end else begin
            thr <= PERIOD_W'(prod >> DUTY_W);
        end
    end

    // Adopt the new threshold only at a period boundary.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            thr_act <= '0;
        end else if (boundary) begin
            thr_act <= thr;
        end
    end

    // Compare flop; idle level while the period is zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm <= PWM_IDLE;
        end else begin
            pwm <= PWM_IDLE ^ (run && (cnt < thr_act));
        end
    end

endmodule

// File: rtl/rgb_pwm_avalon.sv
// rgb_pwm_avalon: Avalon-MM slave driving a 3-bit RGB PWM conduit.
// Macro RGB_PWM_ACTIVE_LOW_EN selects inverted (common-anode) outputs.
module rgb_pwm_avalon
    import rgb_pwm_pkg::*;
#(
    parameter int PERIOD_W = PERIOD_W_DEF,
    parameter int DUTY_W   = DUTY_W_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic [2:0]  rgb_output
);

    localparam logic [DUTY_W:0] ONE_Q = (DUTY_W + 1)'(1) << DUTY_W;

    logic [PERIOD_W-1:0]  period_stage;
    logic [PERIOD_W-1:0]  period_act;
    logic [PERIOD_W-1:0]  cnt;
    logic [2:0][DUTY_W:0] duty_stage;
    logic [DUTY_W:0]      wr_duty;
    logic [31:0]          rd_mux;
    logic                 run;
    logic                 boundary;
    logic                 unused_wdata;

    assign unused_wdata = ^avs_writedata[31:PERIOD_W];

    // Clamp incoming duty values to 1.0.
    always_comb begin
        wr_duty = avs_writedata[DUTY_W:0];
        if (wr_duty > ONE_Q) begin
            wr_duty = ONE_Q;
        end
    end

    // Read mux over the staging registers, zero-extended.
    always_comb begin
        rd_mux = '0;
        unique case (avs_address)
            ADDR_PERIOD: rd_mux[PERIOD_W-1:0] = period_stage;
            ADDR_RED:    rd_mux[DUTY_W:0]     = duty_stage[CH_RED];
            ADDR_GREEN:  rd_mux[DUTY_W:0]     = duty_stage[CH_GREEN];
            ADDR_BLUE:   rd_mux[DUTY_W:0]     = duty_stage[CH_BLUE];
        endcase
    end

    // Staging register writes and registered read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_stage <= '0;
            duty_stage   <= '0;
            avs_readdata <= '0;
        end else begin
            if (avs_write) begin
                unique case (avs_address)
                    ADDR_PERIOD: period_stage <= avs_writedata[PERIOD_W-1:0];
                    ADDR_RED:    duty_stage[CH_RED]   <= wr_duty;
                    ADDR_GREEN:  duty_stage[CH_GREEN] <= wr_duty;
                    ADDR_BLUE:   duty_stage[CH_BLUE]  <= wr_duty;
                endcase
            end
            if (avs_read) begin
                avs_readdata <= rd_mux;
            end
        end
    end

    assign run      = (period_act != '0);
    assign boundary = !run || (cnt == period_act - PERIOD_W'(1));

    // Shared period counter; reloads the active period at each boundary.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            period_act <= '0;
        end else if (boundary) begin
            cnt        <= '0;
            period_act <= period_stage;
        end else begin
            cnt <= cnt + PERIOD_W'(1);
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_ch
        pwm_channel #(
            .PERIOD_W (PERIOD_W),
            .DUTY_W   (DUTY_W)
        ) u_ch (
            .clk          (clk),
            .reset_n      (reset_n),
            .period_stage (period_stage),
            .duty_stage   (duty_stage[i]),
            .cnt          (cnt),
            .boundary     (boundary),
            .run          (run),
            .pwm          (rgb_output[i])
        );
    end

endmodule

// File: tb/tb_rgb_pwm_avalon.sv
// tb_rgb_pwm_avalon: scoreboard bench for the RGB PWM Avalon slave.
// Expected read data and PWM samples are queued, then popped on output.
module tb_rgb_pwm_avalon;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  avs_address = 2'd0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = 32'd0;
    logic [31:0] avs_readdata;
    logic [2:0]  rgb_output;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;
    logic [31:0] rd;
    bit          ok;

    always #5 clk = ~clk;

    rgb_pwm_avalon dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .rgb_output    (rgb_output)
    );

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(posedge clk); #1;
        avs_write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        avs_address = a;
        avs_read    = 1'b1;
        @(posedge clk); #1;
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic wait_rise(input int b, output bit found);
        logic prev;
        found = 1'b0;
        @(negedge clk);
        prev = rgb_output[b];
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clk);
            if (rgb_output[b] && !prev) found = 1'b1;
            prev = rgb_output[b];
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (rgb_output !== 3'b000) begin
            n_err++;
            $display("FAIL reset_rgb: got %b want 000", rgb_output);
        end
        n_vec++;
        if (avs_readdata !== 32'd0) begin
            n_err++;
            $display("FAIL reset_rdata: got %h want 0", avs_readdata);
        end
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            exp_q.push_back(32'd0);
            bus_read(2'(a), rd);
            exp_v = exp_q.pop_front();
            n_vec++;
            if (rd !== exp_v) begin
                n_err++;
                $display("FAIL reset_read%0d: got %h want %h", a, rd, exp_v);
            end
        end
    endtask

    task automatic test_basic_pwm();
        logic r;
        bus_write(2'd0, 32'hAB00_000A);
        bus_write(2'd1, 32'h0000_0800);
        bus_write(2'd2, 32'h0000_1000);
        bus_write(2'd3, 32'h0000_0000);
        exp_q.push_back(32'h0000_000A);
        bus_read(2'd0, rd);
        exp_v = exp_q.pop_front();
        n_vec++;
        if (rd !== exp_v) begin
            n_err++;
            $display("FAIL period_read: got %h want %h", rd, exp_v);
        end
        repeat (30) @(posedge clk);
        wait_rise(2, ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL basic_sync: red never rose, got 0 want 1");
        end
        for (int k = 0; k < 30; k++) begin
            r = ((k % 10) < 5);
            exp_q.push_back({29'd0, r, 1'b1, 1'b0});
        end
        for (int k = 0; k < 30; k++) begin
            if (k > 0) @(negedge clk);
            exp_v = exp_q.pop_front();
            n_vec++;
            if ({29'd0, rgb_output} !== exp_v) begin
                n_err++;
                $display("FAIL basic_pwm[%0d]: got %b want %b",
                         k, rgb_output, exp_v[2:0]);
            end
        end
    endtask

    task automatic test_clamp();
        logic [31:0] wv [4] = '{32'h0000_0FFF, 32'h0000_1000,
                                 32'h0000_1001, 32'h0000_1FFF};
        logic [31:0] ev [4] = '{32'h0000_0FFF, 32'h0000_1000,
                                 32'h0000_1000, 32'h0000_1000};
        for (int i = 0; i < 4; i++) begin
            bus_write(2'd1, wv[i]);
            exp_q.push_back(ev[i]);
            bus_read(2'd1, rd);
            exp_v = exp_q.pop_front();
            n_vec++;
            if (rd !== exp_v) begin
                n_err++;
                $display("FAIL clamp_read%0d: got %h want %h", i, rd, exp_v);
            end
        end
        bus_write(2'd0, 32'd8);
        repeat (30) @(posedge clk);
        for (int k = 0; k < 24; k++) exp_q.push_back(32'b110);
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            exp_v = exp_q.pop_front();
            n_vec++;
            if ({29'd0, rgb_output} !== exp_v) begin
                n_err++;
                $display("FAIL clamp_pwm[%0d]: got %b want %b",
                         k, rgb_output, exp_v[2:0]);
            end
        end
    endtask

    task automatic test_glitch_free();
        logic r;
        bus_write(2'd2, 32'd0);
        bus_write(2'd3, 32'd0);
        bus_write(2'd1, 32'h0000_0400);
        bus_write(2'd0, 32'd20);
        repeat (50) @(posedge clk);
        wait_rise(2, ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL glitch_sync: red never rose, got 0 want 1");
        end
        @(posedge clk);
        @(posedge clk); #1;
        avs_address   = 2'd1;
        avs_writedata = 32'h0000_0C00;
        avs_write     = 1'b1;
        for (int p = 3; p < 40; p++) begin
            r = (p < 20) ? (p < 5) : ((p - 20) < 15);
            exp_q.push_back({29'd0, r, 2'b00});
        end
        @(posedge clk); #1;
        avs_write = 1'b0;
        for (int p = 3; p < 40; p++) begin
            @(negedge clk);
            exp_v = exp_q.pop_front();
            n_vec++;
            if ({29'd0, rgb_output} !== exp_v) begin
                n_err++;
                $display("FAIL glitch_pwm[p=%0d]: got %b want %b",
                         p, rgb_output, exp_v[2:0]);
            end
        end
    endtask

    task automatic test_degenerate();
        bus_write(2'd2, 32'h0000_1000);
        bus_write(2'd0, 32'd0);
        repeat (40) @(posedge clk);
        for (int k = 0; k < 10; k++) exp_q.push_back(32'b000);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            exp_v = exp_q.pop_front();
            n_vec++;
            if ({29'd0, rgb_output} !== exp_v) begin
                n_err++;
                $display("FAIL period0[%0d]: got %b want %b",
                         k, rgb_output, exp_v[2:0]);
            end
        end
        bus_write(2'd1, 32'h0000_0800);
        bus_write(2'd0, 32'd1);
        repeat (10) @(posedge clk);
        for (int k = 0; k < 10; k++) exp_q.push_back(32'b010);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            exp_v = exp_q.pop_front();
            n_vec++;
            if ({29'd0, rgb_output} !== exp_v) begin
                n_err++;
                $display("FAIL period1[%0d]: got %b want %b",
                         k, rgb_output, exp_v[2:0]);
            end
        end
    endtask

    task automatic test_readback();
        logic [31:0] tail_exp [3] = '{32'd0, 32'h0000_0800, 32'd1};
        logic [1:0]  tail_adr [3] = '{2'd3, 2'd1, 2'd0};
        bus_write(2'd2, 32'h0000_0123);
        @(posedge clk); #1;
        avs_address   = 2'd2;
        avs_read      = 1'b1;
        avs_write     = 1'b1;
        avs_writedata = 32'h0000_0456;
        exp_q.push_back(32'h0000_0123);
        @(posedge clk); #1;
        avs_read  = 1'b0;
        avs_write = 1'b0;
        exp_v = exp_q.pop_front();
        n_vec++;
        if (avs_readdata !== exp_v) begin
            n_err++;
            $display("FAIL rw_same: got %h want %h", avs_readdata, exp_v);
        end
        exp_q.push_back(32'h0000_0123);
        @(posedge clk); #1;
        exp_v = exp_q.pop_front();
        n_vec++;
        if (avs_readdata !== exp_v) begin
            n_err++;
            $display("FAIL rd_hold: got %h want %h", avs_readdata, exp_v);
        end
        avs_address = 2'd2;
        avs_read    = 1'b1;
        exp_q.push_back(32'h0000_0123);
        exp_q.push_back(32'h0000_0456);
        #2;
        exp_v = exp_q.pop_front();
        n_vec++;
        if (avs_readdata !== exp_v) begin
            n_err++;
            $display("FAIL rd_early: got %h want %h", avs_readdata, exp_v);
        end
        @(posedge clk); #1;
        avs_read = 1'b0;
        exp_v = exp_q.pop_front();
        n_vec++;
        if (avs_readdata !== exp_v) begin
            n_err++;
            $display("FAIL rd_lat1: got %h want %h", avs_readdata, exp_v);
        end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(tail_exp[i]);
            bus_read(tail_adr[i], rd);
            exp_v = exp_q.pop_front();
            n_vec++;
            if (rd !== exp_v) begin
                n_err++;
                $display("FAIL rd_addr%0d: got %h want %h",
                         tail_adr[i], rd, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        bus_write(2'd2, 32'h0000_1000);
        bus_write(2'd0, 32'd10);
        repeat (30) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (rgb_output[1] !== 1'b1) begin
            n_err++;
            $display("FAIL mid_green: got %b want 1", rgb_output[1]);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (rgb_output !== 3'b000) begin
            n_err++;
            $display("FAIL mid_async: got %b want 000", rgb_output);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            exp_q.push_back(32'd0);
            bus_read(2'(a), rd);
            exp_v = exp_q.pop_front();
            n_vec++;
            if (rd !== exp_v) begin
                n_err++;
                $display("FAIL mid_read%0d: got %h want %h", a, rd, exp_v);
            end
        end
        for (int k = 0; k < 5; k++) exp_q.push_back(32'b000);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            exp_v = exp_q.pop_front();
            n_vec++;
            if ({29'd0, rgb_output} !== exp_v) begin
                n_err++;
                $display("FAIL mid_idle[%0d]: got %b want %b",
                         k, rgb_output, exp_v[2:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_pwm();
        test_clamp();
        test_glitch_free();
        test_degenerate();
        test_readback();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: sim time %0t exceeded limit 500000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
